// File: rtl/xor_pipe_chain.sv
// -----------------------------------------------------------------------------
// xor_pipe_chain
//
// Purpose:
//   A DEPTH-stage register chain with ready/valid handshaking. Stage 0 captures
//   s1_i. Each later stage k captures (stage k-1 XOR r_i slice k-1). The output
//   is the last stage XOR s2_i, and that XOR is combinational. The whole chain
//   stalls as one unit: an empty last stage or a ready consumer lets it advance.
//   A saturating counter tracks the number of delivered beats.
//
// Parameters:
//   WIDTH  - bit width of each data lane
//   DEPTH  - number of register stages (2..16)
//   CNT_W  - width of the delivered-beat counter
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   clr_i        in   synchronous flush of all valid bits
//   s1_i         in   [WIDTH]            data entering stage 0
//   r_i          in   [WIDTH*(DEPTH-1)]  per-stage XOR operands (slice k-1 -> stage k)
//   s2_i         in   [WIDTH]            output-side XOR operand
//   in_valid_i   in   input beat offered
//   in_ready_o   out  chain advances this cycle
//   o_o          out  [WIDTH]            last stage XOR s2_i
//   out_valid_o  out  o_o holds a valid beat
//   out_ready_i  in   consumer accepts o_o
//   cnt_o        out  [CNT_W]            delivered beats, saturating
// -----------------------------------------------------------------------------
module xor_pipe_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic [WIDTH-1:0]           s1_i,
    input  logic [WIDTH*(DEPTH-1)-1:0] r_i,
    input  logic [WIDTH-1:0]           s2_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [WIDTH-1:0]           o_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [CNT_W-1:0]           cnt_o
);

    logic [DEPTH-1:0][WIDTH-1:0] st_q;
    logic [DEPTH-1:0][WIDTH-1:0] st_shift;
    logic [DEPTH-1:0][WIDTH-1:0] st_d;
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic                        adv;
    logic                        handshake;

    // The whole chain moves together. Only a valid, unaccepted last stage
    // blocks it. Invalid stages in the middle are not squeezed out.
    assign adv       = out_ready_i | ~v_q[DEPTH-1];
    assign handshake = v_q[DEPTH-1] & out_ready_i;

    // Candidate contents of every stage if the chain shifts this cycle.
    assign st_shift[0] = s1_i;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign st_shift[gi] = st_q[gi-1] ^ r_i[(gi-1)*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        st_d  = st_q;
        v_d   = v_q;
        cnt_d = cnt_q;
        // A flush overrides any advance. The data registers keep their
        // contents, and only the valid bits are cleared.
        if (clr_i) begin
            v_d = '0;
        end else if (adv) begin
            st_d = st_shift;
            v_d  = {v_q[DEPTH-2:0], in_valid_i};
        end
        // A delivery in a flush cycle still counts, because the consumer
        // took the beat.
        if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q  <= '0;
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready_o  = adv;
    assign o_o         = st_q[DEPTH-1] ^ s2_i;
    assign out_valid_o = v_q[DEPTH-1];
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_xor_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_xor_pipe_chain
//
// Self-checking bench for xor_pipe_chain.
//   dut   : WIDTH=8, DEPTH=4, CNT_W=4. Scoreboard-driven streaming, stalls,
//           flush, asynchronous reset and counter saturation.
//   dut_b : WIDTH=1, DEPTH=2. Two-flop baseline with time-varying r and s2.
// -----------------------------------------------------------------------------
module tb_xor_pipe_chain;

    // ---------------- main instance ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  s1;
    logic [23:0] r;
    logic [7:0]  s2;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  o;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  cnt;

    // ---------------- small instance ----------------
    logic        b_clr;
    logic [0:0]  b_s1;
    logic [0:0]  b_r;
    logic [0:0]  b_s2;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [0:0]  b_o;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    xor_pipe_chain #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .s1_i(s1), .r_i(r), .s2_i(s2),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .o_o(o),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .cnt_o(cnt)
    );

    xor_pipe_chain #(.WIDTH(1), .DEPTH(2), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .s1_i(b_s1), .r_i(b_r), .s2_i(b_s2),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .o_o(b_o),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .cnt_o(b_cnt)
    );

    // ---------------- checking ----------------
    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] d;
        int         acc;
        bit         lat_ok;
    } exp_t;

    exp_t       sb[$];
    int         cyc      = 0;
    bit         lat_mode = 1'b1;
    logic [3:0] cnt_exp  = 4'd0;

    // The r slices are constant, so every beat picks up 0xF0^0x0F^0xAA = 0x55.
    localparam logic [7:0] R_ALL = 8'h55;

    // One cycle: drive inputs at the falling edge, check the outputs, then
    // update the model for the next rising edge.
    task automatic step(input bit iv, input logic [7:0] d1, input bit ordy,
                        input bit clr_v, input logic [7:0] d2);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        s1        = d1;
        out_ready = ordy;
        clr       = clr_v;
        s2        = d2;
        #1;
        check_eq("cnt", 32'(cnt), 32'(cnt_exp));
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("data", 32'(o), 32'(e.d ^ d2));
                if (e.lat_ok) check_eq("latency", 32'(cyc - e.acc), 32'd4);
                $display("beat out: o=0x%02h exp=0x%02h cyc=%0d", o, e.d ^ d2, cyc);
                if (cnt_exp != 4'hF) cnt_exp = cnt_exp + 4'd1;
            end
        end
        if (clr_v) begin
            sb.delete();
        end else if (iv && in_ready) begin
            e.d      = d1 ^ R_ALL;
            e.acc    = cyc;
            e.lat_ok = lat_mode;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 8'(i * 37));
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [0:0] bs1 [12];
    logic [0:0] br  [12];
    logic [0:0] bs2 [12];

    initial begin
        rst_n = 1'b0; clr = 1'b0; s1 = 8'h00; r = {8'hAA, 8'h0F, 8'hF0};
        s2 = 8'h3C; in_valid = 1'b0; out_ready = 1'b0;
        b_clr = 1'b0; b_s1 = 1'b0; b_r = 1'b0; b_s2 = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;

        // Reset state.
        #3;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_cnt",   32'(cnt),       32'd0);
        check_eq("rst_ready", 32'(in_ready),  32'd1);
        check_eq("rst_o",     32'(o),         32'h3C);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stream 0x01..0x08 with s2=0. Expect 0x54..0x5D at latency 4 steps.
        lat_mode = 1'b1;
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 8'h00);
        drain(5);
        check_eq("cnt_after8", 32'(cnt), 32'd8);

        // Backpressure. Fill with a blocked consumer, then hold for 5 cycles.
        lat_mode = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0, 8'h00);
            check_eq("stall_ready", 32'(in_ready),  32'd0);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_o",     32'(o),         32'(sb[0].d));
        end
        for (int i = 0; i < 8; i++)
            step(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                 1'($urandom_range(1, 0)), 1'b0, 8'($urandom_range(255, 0)));
        drain(8);

        // Asynchronous reset between edges with a full pipeline.
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        s2 = 8'hA5;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_cnt",   32'(cnt),       32'd0);
        check_eq("arst_o",     32'(o),         32'hA5);
        check_eq("arst_ready", 32'(in_ready),  32'd1);
        sb.delete();
        cnt_exp = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat_mode = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h11);
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);

        // Flush with one beat being delivered and 3 more in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 8'h00);
        step(1'b1, 8'h99, 1'b1, 1'b1, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check_eq("clr_valid", 32'(out_valid), 32'd0);
        check_eq("clr_cnt",   32'(cnt),       32'd1);
        step(1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        drain(6);

        // Random bubbles and random s2, with the consumer always ready.
        for (int i = 0; i < 10; i++)
            step(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 1'b1, 1'b0,
                 8'($urandom_range(255, 0)));
        drain(5);

        // Saturation. Deliver more than 20 beats in total, so cnt stays at 15.
        for (int i = 0; i < 20; i++)
            step(1'b1, 8'($urandom_range(255, 0)), 1'b1, 1'b0, 8'($urandom_range(255, 0)));
        drain(6);
        check_eq("cnt_sat", 32'(cnt), 32'd15);

        // Two-flop baseline, WIDTH=1, DEPTH=2.
        @(negedge clk);
        b_s1 = 1'b1; b_r = 1'b0; b_s2 = 1'b1; b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0; b_s1 = 1'b0; b_r = 1'b0;
        #1;
        check_eq("b_early_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("b_valid_r0", 32'(b_out_valid), 32'd1);
        check_eq("b_o_r0",     32'(b_o),         32'd0);
        $display("b beat: o=%0d exp=0", b_o);
        @(negedge clk);
        b_s1 = 1'b1; b_in_valid = 1'b1; b_r = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0; b_s1 = 1'b0; b_r = 1'b1;
        @(negedge clk);
        b_r = 1'b0;
        #1;
        check_eq("b_valid_r1", 32'(b_out_valid), 32'd1);
        check_eq("b_o_r1",     32'(b_o),         32'd1);
        $display("b beat: o=%0d exp=1", b_o);
        for (int t = 0; t < 12; t++) begin
            bs1[t] = 1'($urandom_range(1, 0));
            br[t]  = 1'($urandom_range(1, 0));
            bs2[t] = 1'($urandom_range(1, 0));
        end
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            b_in_valid = (t < 10);
            b_s1 = bs1[t]; b_r = br[t]; b_s2 = bs2[t];
            #1;
            if (t >= 2) begin
                check_eq("b_stream_valid", 32'(b_out_valid), 32'd1);
                check_eq("b_stream_o", 32'(b_o), 32'(bs1[t-2] ^ br[t-1] ^ bs2[t]));
                $display("b beat: o=%0d exp=%0d", b_o, bs1[t-2] ^ br[t-1] ^ bs2[t]);
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        check_eq("b_cnt", 32'(b_cnt), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/xor_pipe_chain.md
XOR_PIPE_CHAIN -- requirements
Module: xor_pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 1, bit width of each data lane.
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 16, width of the completed-transfer counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clr_i  input  1  synchronous flush; invalidates all stages.
REQ-007 SHALL have port s1_i  input  WIDTH  data entering stage 0.
REQ-008 SHALL have port r_i  input  WIDTH*(DEPTH-1)  per-stage XOR operands; slice k-1 feeds stage k.
REQ-009 SHALL have port s2_i  input  WIDTH  output-side XOR operand, combinational.
REQ-010 SHALL have port in_valid_i  input  1  s1_i/r_i-carried beat offered.
REQ-011 SHALL have port in_ready_o  output  1  chain can advance this cycle.
REQ-012 SHALL have port o_o  output  WIDTH  result = last stage XOR s2_i.
REQ-013 SHALL have port out_valid_o  output  1  o_o holds a valid beat.
REQ-014 SHALL have port out_ready_i  input  1  consumer accepts o_o.
REQ-015 SHALL have port cnt_o  output  CNT_W  number of beats delivered, saturating.

Function
REQ-016 SHALL hold data registers st[0..DEPTH-1] (WIDTH each) and valid bits v[0..DEPTH-1].
REQ-017 SHALL compute adv = out_ready_i OR NOT v[DEPTH-1]; in_ready_o = adv, combinational.
REQ-018 On adv: st[0] <= s1_i, v[0] <= in_valid_i.
REQ-019 On adv, for k=1..DEPTH-1: st[k] <= st[k-1] XOR r_i slice k-1, v[k] <= v[k-1].
REQ-020 When adv=0 all st and v SHALL hold; r_i and s1_i are ignored that cycle.
REQ-021 Global stall only; no bubble collapsing -- invalid stages still shift when adv=1.
REQ-022 o_o = st[DEPTH-1] XOR s2_i, combinational; out_valid_o = v[DEPTH-1].
REQ-023 Latency: a beat accepted at edge n appears on out_valid_o after edge n+DEPTH-1, given no stalls.
REQ-024 Throughput: one beat per cycle while out_ready_i=1.
REQ-025 Data of an invalid stage is don't-care but SHALL still shift deterministically (no X from reset state).
REQ-026 cnt_o increments by 1 on each cycle with out_valid_o=1 and out_ready_i=1; saturates at 2^CNT_W-1, no wrap.
REQ-027 clr_i=1 SHALL clear all v to 0 at the next edge, override any advance, and leave st and cnt_o unchanged.
REQ-028 clr_i and a handshake in the same cycle: handshake still counts in cnt_o; the input beat is dropped.
REQ-029 With DEPTH=2, in_valid_i=1, out_ready_i=1: o_o = (registered s1 XOR r) registered, XOR s2 -- the two-flop chain baseline.

Reset
REQ-030 rst_ni=0 SHALL asynchronously clear all st to 0, all v to 0, cnt_o to 0.
REQ-031 During and after reset: out_valid_o=0, o_o=s2_i, in_ready_o=1.
REQ-032 Reset deassertion mid-stream SHALL discard all in-flight beats; first output follows the next accepted beat.

Verification
REQ-033 WIDTH=1, DEPTH=2, out_ready_i=1: s1_i=1, r_i=0, s2_i=1 -> out_valid_o=1 two edges later, o_o=0; with r_i=1 at stage-1 load -> o_o=1.
REQ-034 WIDTH=8, DEPTH=4: stream 0x01..0x08, r_i slices 0xF0,0x0F,0xAA, s2_i=0 -> outputs 0x01^0x55=0x54 .. 0x08^0x55=0x5D in order, latency 3, cnt_o=8.
REQ-035 Backpressure: pipeline full, out_ready_i=0 for 5 cycles -> in_ready_o=0, o_o and st stable, cnt_o unchanged; release -> no beat lost or duplicated.
REQ-036 clr_i pulse with 3 beats in flight -> out_valid_o=0 next cycle, cnt_o unchanged, next accepted beat emerges at normal latency.
REQ-037 CNT_W=4: deliver 20 beats -> cnt_o saturates at 15 and stays.
REQ-038 Assert rst_ni=0 asynchronously between edges with full pipeline -> out_valid_o and cnt_o drop to 0 immediately, st=0.
